// File: rtl/ipsmacge_pkg.sv
// Shared definitions for the GE MAC priority pause generator: class states,
// quantum clock default and the per-class request struct.
package ipsmacge_pkg;
  typedef enum logic [1:0] {
    PFC_IDLE      = 2'd0,
    PFC_XOFF_PEND = 2'd1,
    PFC_ACTIVE    = 2'd2,
    PFC_XON_PEND  = 2'd3
  } pfc_st_e;

  localparam int QCLK_DEF = 64;
  localparam int XON_QNT  = 0;

  // pend: class wants a slot in the next frame; xoff: that slot carries quanta
  typedef struct packed {
    logic pend;
    logic xoff;
  } pfc_req_t;
endpackage

// File: rtl/ipsmacge_pfcch.sv
// One priority class: XOFF/XON state machine plus a saturating refresh
// counter measured in pause quanta.
module ipsmacge_pfcch
  import ipsmacge_pkg::*;
#(
  parameter int QW = 16
) (
  input  logic          txclk,
  input  logic          txrst,
  input  logic          clr,
  input  logic          pauen,
  input  logic          qtick,
  input  logic          snap,
  input  logic [QW-1:0] prefr,
  output pfc_req_t      req
);
  pfc_st_e       st, st_nxt;
  logic [QW-1:0] rcnt;

  always_ff @(posedge txclk) begin
    if (txrst || clr) st <= PFC_IDLE;
    else              st <= st_nxt;
  end

  // A snapshot always wins: the frame already carries this class's current state.
  always_comb begin
    st_nxt = st;
    case (st)
      PFC_IDLE:      if (pauen) st_nxt = PFC_XOFF_PEND;
      PFC_XOFF_PEND: if (snap) st_nxt = PFC_ACTIVE;
                     else if (!pauen) st_nxt = PFC_XON_PEND;
      PFC_ACTIVE:    if (!pauen) st_nxt = PFC_XON_PEND;
                     else if (rcnt >= prefr) st_nxt = PFC_XOFF_PEND;
      PFC_XON_PEND:  if (snap) st_nxt = PFC_IDLE;
                     else if (pauen) st_nxt = PFC_XOFF_PEND;
      default:       st_nxt = PFC_IDLE;
    endcase
  end

  always_ff @(posedge txclk) begin
    if (txrst || clr)                               rcnt <= '0;
    else if (st == PFC_XOFF_PEND && snap)           rcnt <= '0;
    else if (st == PFC_ACTIVE && qtick && rcnt < prefr) rcnt <= rcnt + QW'(1);
  end

  assign req.pend = (st == PFC_XOFF_PEND) || (st == PFC_XON_PEND);
  assign req.xoff = (st == PFC_XOFF_PEND);
endmodule

// File: rtl/ipsmacge_pfcgen.sv
// Multi-class pause frame generator: quantum prescaler, per-class FSMs,
// frame snapshot registers and request aggregation.
module ipsmacge_pfcgen
  import ipsmacge_pkg::*;
#(
  parameter int NCH  = 8,
  parameter int QW   = 16,
  parameter int QCLK = QCLK_DEF
) (
  input  logic              txclk,
  input  logic              txrst,
  input  logic [NCH-1:0]    ipauen,
  input  logic [NCH-1:0]    ipaudi,
  input  logic              possfd,
  input  logic              ppaudis,
  input  logic [QW-1:0]     pquanta,
  input  logic [QW-1:0]     prefr,
  output logic              opauen,
  output logic [NCH-1:0]    ocev,
  output logic [NCH*QW-1:0] oqnt,
  output logic [NCH-1:0]    opaudi
);
  localparam int PW = (QCLK > 1) ? $clog2(QCLK) : 1;

  logic [PW-1:0]              pcnt;
  logic                       qtick;
  pfc_req_t [NCH-1:0]         req;
  logic [NCH-1:0]             pend;
  logic [NCH-1:0][QW-1:0]     qnt_q;

  assign qtick = (pcnt == PW'(QCLK - 1));

  always_ff @(posedge txclk) begin
    if (txrst || ppaudis || qtick) pcnt <= '0;
    else                           pcnt <= pcnt + PW'(1);
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    ipsmacge_pfcch #(.QW(QW)) u_ch (
      .txclk (txclk),
      .txrst (txrst),
      .clr   (ppaudis),
      .pauen (ipauen[i]),
      .qtick (qtick),
      .snap  (possfd),
      .prefr (prefr),
      .req   (req[i])
    );
    assign pend[i] = req[i].pend;
  end

  // Snapshot samples class state as registered before the possfd edge.
  always_ff @(posedge txclk) begin
    if (txrst || ppaudis) begin
      opauen <= 1'b0;
      opaudi <= '0;
      ocev   <= '0;
      qnt_q  <= '0;
    end else begin
      opauen <= |pend;
      opaudi <= ipaudi;
      if (possfd) begin
        for (int i = 0; i < NCH; i++) begin
          ocev[i]  <= req[i].pend;
          qnt_q[i] <= (req[i].pend && req[i].xoff) ? pquanta : QW'(XON_QNT);
        end
      end
    end
  end

  assign oqnt = qnt_q;
endmodule

// File: tb/tb_ipsmacge_pfcgen.sv
// Bench for ipsmacge_pfcgen: scripted class sequences with a frame scoreboard
// and a small vector table for the received-pause passthrough.
module tb_ipsmacge_pfcgen;
  logic         txclk = 1'b0;
  logic         txrst;
  logic [7:0]   ipauen, ipaudi;
  logic         possfd, ppaudis;
  logic [15:0]  pquanta, prefr;
  logic         opauen;
  logic [7:0]   ocev, opaudi;
  logic [127:0] oqnt;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [7:0] cev; logic [127:0] qnt; } frm_t;
  frm_t sb[$];

  typedef struct { logic [7:0] di; logic dis; logic [7:0] exp; } dvec_t;
  dvec_t dtab[6];

  ipsmacge_pfcgen #(.NCH(8), .QW(16), .QCLK(64)) dut (
    .txclk   (txclk),
    .txrst   (txrst),
    .ipauen  (ipauen),
    .ipaudi  (ipaudi),
    .possfd  (possfd),
    .ppaudis (ppaudis),
    .pquanta (pquanta),
    .prefr   (prefr),
    .opauen  (opauen),
    .ocev    (ocev),
    .oqnt    (oqnt),
    .opaudi  (opaudi)
  );

  always #5 txclk = ~txclk;

  task automatic tick();
    @(posedge txclk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] qv(input int c, input logic [15:0] v);
    logic [127:0] r;
    r = '0;
    r[c*16 +: 16] = v;
    return r;
  endfunction

  task automatic wait_pauen(input string nm, input int maxc);
    int n;
    n = 0;
    while (opauen !== 1'b1 && n < maxc) begin
      tick();
      n++;
    end
    chk(nm, {127'd0, opauen}, 128'd1);
  endtask

  // Expected frame is queued as possfd is driven and retired after the edge.
  task automatic send_frame(input string nm, input logic [7:0] cev, input logic [127:0] qnt);
    frm_t f;
    f.cev = cev;
    f.qnt = qnt;
    sb.push_back(f);
    possfd = 1'b1;
    tick();
    possfd = 1'b0;
    f = sb.pop_front();
    chk({nm, "_ocev"}, {120'd0, ocev}, {120'd0, f.cev});
    chk({nm, "_oqnt"}, oqnt, f.qnt);
  endtask

  initial begin
    int n, bad;
    logic [127:0] q;

    dtab[0] = '{8'hA5, 1'b0, 8'hA5};
    dtab[1] = '{8'h5A, 1'b0, 8'h5A};
    dtab[2] = '{8'hA5, 1'b1, 8'h00};
    dtab[3] = '{8'hFF, 1'b0, 8'hFF};
    dtab[4] = '{8'hFF, 1'b1, 8'h00};
    dtab[5] = '{8'h3C, 1'b0, 8'h3C};

    txrst = 1'b1; ipauen = '0; ipaudi = '0; possfd = 1'b0; ppaudis = 1'b0;
    pquanta = 16'hFFFF; prefr = 16'd4;
    repeat (3) tick();
    chk("rst_opauen", {127'd0, opauen}, 128'd0);
    chk("rst_ocev", {120'd0, ocev}, 128'd0);
    chk("rst_oqnt", oqnt, 128'd0);
    chk("rst_opaudi", {120'd0, opaudi}, 128'd0);
    txrst = 1'b0;

    // Basic XOFF on class 2, latency and fall
    ipauen = 8'h04;
    tick();
    chk("lat1", {127'd0, opauen}, 128'd0);
    tick();
    chk("lat2", {127'd0, opauen}, 128'd1);
    send_frame("xoff2", 8'h04, qv(2, 16'hFFFF));
    tick();
    chk("fall2", {127'd0, opauen}, 128'd0);
    ipauen = 8'h00;
    tick();
    wait_pauen("xon2_req", 4);
    send_frame("xon2", 8'h04, 128'd0);
    tick();
    chk("fall2b", {127'd0, opauen}, 128'd0);

    // Refresh on class 0: prefr=4 quanta of 64 clocks
    ipauen = 8'h01;
    tick();
    wait_pauen("xoff0_req", 4);
    send_frame("xoff0", 8'h01, qv(0, 16'hFFFF));
    for (int k = 0; k < 2; k++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (opauen !== 1'b1 && n < 400);
      chk("refr_period", {127'd0, (n >= 193 && n <= 260)}, 128'd1);
      send_frame("refr0", 8'h01, qv(0, 16'hFFFF));
    end

    // XON on class 0, then it must stay quiet
    ipauen = 8'h00;
    tick();
    wait_pauen("xon0_req", 4);
    send_frame("xon0", 8'h01, 128'd0);
    tick();
    chk("fall0", {127'd0, opauen}, 128'd0);
    bad = 0;
    repeat (300) begin
      tick();
      if (opauen) bad++;
    end
    chk("idle0", 128'(bad), 128'd0);

    // Request in the same cycle as possfd misses that frame
    ipauen = 8'h02;
    tick();
    wait_pauen("c1_req", 4);
    ipauen = 8'h0A;
    send_frame("sim1", 8'h02, qv(1, 16'hFFFF));
    tick();
    chk("rehigh", {127'd0, opauen}, 128'd1);
    send_frame("sim3", 8'h08, qv(3, 16'hFFFF));
    ipauen = 8'h00;
    tick();
    tick();
    wait_pauen("xon13_req", 4);
    send_frame("xon13", 8'h0A, 128'd0);
    tick();

    // Cancel before snapshot sends XON; mixed frame; empty snapshot
    ipauen = 8'h20;
    tick();
    ipauen = 8'h00;
    tick();
    wait_pauen("c5_req", 4);
    send_frame("cancel5", 8'h20, 128'd0);
    tick();
    chk("fall5", {127'd0, opauen}, 128'd0);
    pquanta = 16'h1234;
    ipauen = 8'h42;
    tick();
    wait_pauen("mix_req", 4);
    send_frame("mix16", 8'h42, qv(1, 16'h1234) | qv(6, 16'h1234));
    tick();
    send_frame("empty", 8'h00, 128'd0);

    // Global disable with all classes engaged
    ipauen = 8'hFF;
    tick();
    wait_pauen("all_req", 4);
    q = '0;
    for (int c = 0; c < 8; c++) if (c != 1 && c != 6) q |= qv(c, 16'h1234);
    send_frame("all", 8'hBD, q);
    ppaudis = 1'b1; ipauen = 8'h00; ipaudi = 8'hA5;
    tick();
    chk("dis_ocev", {120'd0, ocev}, 128'd0);
    chk("dis_oqnt", oqnt, 128'd0);
    chk("dis_opauen", {127'd0, opauen}, 128'd0);
    chk("dis_opaudi", {120'd0, opaudi}, 128'd0);
    ppaudis = 1'b0;
    bad = 0;
    repeat (5) begin
      tick();
      if (opauen) bad++;
    end
    chk("dis_noxon", 128'(bad), 128'd0);

    // Received-pause passthrough table
    for (int v = 0; v < 6; v++) begin
      ipaudi = dtab[v].di;
      ppaudis = dtab[v].dis;
      tick();
      chk($sformatf("opaudi_%0d", v), {120'd0, opaudi}, {120'd0, dtab[v].exp});
    end
    ppaudis = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
